// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - FWFT instruction queue between fetch and decode with flush
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      InInstruction,
  input  logic [31:0]      InPCPlus4,
  input  logic             InValid,
  output logic             InReady,
  output logic [31:0]      OutInstruction,
  output logic [31:0]      OutPCPlus4,
  output logic             OutValid,
  input  logic             OutReady,
  input  logic             Flush,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [63:0]      head;

  // Ready/valid come only from registered state; a full queue refuses a push even while popping
  assign InReady  = (count_q != FullCount);
  assign OutValid = (count_q != '0);
  assign Count    = count_q;

  // Flush cancels both handshakes so the offered entry is dropped and the head is kept
  assign push = InValid & InReady & ~Flush;
  assign pop  = OutValid & OutReady & ~Flush;

  // Head entry, forced to NOP/zero when empty so decode never sees stale storage
  always_comb begin
    head           = mem_q[rd_ptr_q];
    OutInstruction = OutValid ? head[63:32] : 32'h0000_0000;
    OutPCPlus4     = OutValid ? head[31:0]  : 32'h0000_0000;
  end

  // Next-state pointers and occupancy; flush returns everything to the empty origin
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  // Pointer and count registers, cleared asynchronously on reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; only the pointers decide what is valid
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {InInstruction, InPCPlus4};
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - scoreboard bench for fetch_decode_queue
module tb_fetch_decode_queue;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] InInstruction;
  logic [31:0] InPCPlus4;
  logic        InValid;
  logic        InReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPCPlus4;
  logic        OutValid;
  logic        OutReady;
  logic        Flush;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  fetch_decode_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .InInstruction(InInstruction), .InPCPlus4(InPCPlus4),
    .InValid(InValid), .InReady(InReady),
    .OutInstruction(OutInstruction), .OutPCPlus4(OutPCPlus4),
    .OutValid(OutValid), .OutReady(OutReady),
    .Flush(Flush), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every consumed head against the scoreboard; a flush empties it
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge Clk);
      if (Reset && Flush) begin
        sb.delete();
      end else if (Reset && OutValid && OutReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %h expected none", {OutInstruction, OutPCPlus4});
        end else begin
          e = sb.pop_front();
          check("pop_order", {OutInstruction, OutPCPlus4}, e);
        end
      end
    end
  endtask

  // One cycle of stimulus; exp_push records entries the bench expects to be accepted
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic exp_push);
    InValid       = v;
    InInstruction = ins;
    InPCPlus4     = pc;
    OutReady      = ordy;
    Flush         = fl;
    if (exp_push) sb.push_back({ins, pc});
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    OutReady = 1'b0;
    Flush = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    InInstruction = '0;
    InPCPlus4 = '0;
    InValid = 1'b0;
    OutReady = 1'b0;
    Flush = 1'b0;
    fork
      monitor();
    join_none

    // Reset / empty
    repeat (2) @(posedge Clk);
    #1;
    check("rst_count", 64'(Count), 64'd0);
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_inready", 64'(InReady), 64'd1);
    check("rst_outinstr", 64'(OutInstruction), 64'h0);
    Reset = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("empty_pop_count", 64'(Count), 64'd0);

    // Fill to full
    cyc(1'b1, 32'h8C010004, 32'h4,  1'b0, 1'b0, 1'b1);
    check("first_push_valid", 64'(OutValid), 64'd1);
    cyc(1'b1, 32'h8C020008, 32'h8,  1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h00221820, 32'hC,  1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hAC03000C, 32'h10, 1'b0, 1'b0, 1'b1);
    check("full_count", 64'(Count), 64'd4);
    check("full_inready", 64'(InReady), 64'd0);
    check("full_head", {OutInstruction, OutPCPlus4}, {32'h8C010004, 32'h4});
    cyc(1'b1, 32'h12345678, 32'h14, 1'b0, 1'b0, 1'b0);
    check("full_push_ignored", 64'(Count), 64'd4);

    // Drain with pointer wrap
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("after_pop2_count", 64'(Count), 64'd2);
    cyc(1'b1, 32'h08000000, 32'h14, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h00000000, 32'h18, 1'b0, 1'b0, 1'b1);
    check("wrap_full_count", 64'(Count), 64'd4);
    repeat (4) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drained_outvalid", 64'(OutValid), 64'd0);
    check("drained_count", 64'(Count), 64'd0);
    check("drained_outinstr", 64'(OutInstruction), 64'h0);

    // Simultaneous push/pop at Count=2, then full with pop
    cyc(1'b1, 32'hA0000001, 32'h20, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hA0000002, 32'h24, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hA0000003, 32'h28, 1'b1, 1'b0, 1'b1);
    check("pushpop_count2", 64'(Count), 64'd2);
    check("pushpop_head", {OutInstruction, OutPCPlus4}, {32'hA0000002, 32'h24});
    cyc(1'b1, 32'hA0000004, 32'h2C, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hA0000005, 32'h30, 1'b0, 1'b0, 1'b1);
    check("refill_count", 64'(Count), 64'd4);
    cyc(1'b1, 32'hDEADBEEF, 32'h34, 1'b1, 1'b0, 1'b0);
    check("full_pop_push_count", 64'(Count), 64'd3);
    check("full_pop_push_inready", 64'(InReady), 64'd1);

    // Flush with push and pop in the same cycle at Count=3
    cyc(1'b1, 32'hBADBAD00, 32'h38, 1'b1, 1'b1, 1'b0);
    check("flush_count", 64'(Count), 64'd0);
    check("flush_outvalid", 64'(OutValid), 64'd0);
    check("flush_inready", 64'(InReady), 64'd1);
    check("flush_sb_empty", 64'(sb.size()), 64'd0);
    cyc(1'b1, 32'h1000FFFF, 32'h40, 1'b0, 1'b0, 1'b1);
    check("post_flush_head", {OutInstruction, OutPCPlus4}, {32'h1000FFFF, 32'h40});
    check("post_flush_count", 64'(Count), 64'd1);
    cyc(1'b1, 32'hB0000001, 32'h44, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hB0000002, 32'h48, 1'b0, 1'b0, 1'b1);
    check("pre_reset_count", 64'(Count), 64'd3);

    // Async reset between edges
    #2;
    Reset = 1'b0;
    sb.delete();
    #1;
    check("async_rst_count", 64'(Count), 64'd0);
    check("async_rst_outvalid", 64'(OutValid), 64'd0);
    check("async_rst_inready", 64'(InReady), 64'd1);
    check("async_rst_outinstr", 64'(OutInstruction), 64'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    cyc(1'b1, 32'hC0000001, 32'h50, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hC0000002, 32'h54, 1'b0, 1'b0, 1'b1);
    check("resume_count", 64'(Count), 64'd2);
    check("resume_head", {OutInstruction, OutPCPlus4}, {32'hC0000001, 32'h50});
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("final_count", 64'(Count), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

First-word-fall-through instruction queue between the InstructionFetchUnit and the decode stage. Each entry holds the fetched 32-bit instruction and its PC+4. It decouples fetch from decode stalls with a valid/ready handshake on both sides. A single-cycle Flush discards all queued entries on a taken branch or jump.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2
- PTR_W, 2: log2(DEPTH); pointer width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- InInstruction  in  32  instruction from fetch
- InPCPlus4  in  32  PC+4 of that instruction
- InValid  in  1  fetch offers an entry this cycle
- InReady  out  1  queue can accept an entry
- OutInstruction  out  32  head instruction to decode
- OutPCPlus4  out  32  head PC+4 to decode
- OutValid  out  1  head entry is valid
- OutReady  in  1  decode consumes head this cycle
- Flush  in  1  discard all entries (branch/jump redirect)
- Count  out  PTR_W+1  number of valid entries, 0..DEPTH

## Operation
- Storage: DEPTH × 64-bit registers {instruction, PC+4}; write pointer WrPtr and read pointer RdPtr, each PTR_W bits, wrapping modulo DEPTH; Count register PTR_W+1 bits.
- Push = InValid & InReady & ~Flush: write entry at WrPtr, WrPtr+1.
- Pop = OutValid & OutReady & ~Flush: RdPtr+1.
- Count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- InReady = (Count != DEPTH); purely from registered state, no dependence on OutReady. A full queue refuses a push even when a pop happens the same cycle.
- OutValid = (Count != 0).
- OutInstruction/OutPCPlus4 = entry at RdPtr when OutValid, else 32'h00000000 (MIPS NOP) and 32'h00000000. They are never undefined.
- Flush: at the next edge, Count=0, WrPtr=0, RdPtr=0. Flush overrides any push and pop in the same cycle, so the offered entry is dropped and the head is not consumed.
- Empty: a pop is impossible because OutValid=0. OutReady is ignored.
- Full: a push is impossible because InReady=0. InValid is ignored, and fetch must hold its PC.
- Storage contents are never cleared; only pointers and Count reset.

## Timing
- Reset asserted (low) at any time, including mid-transfer: immediately and asynchronously Count=0, WrPtr=0, RdPtr=0, so OutValid=0, InReady=1, Out* = 0. State holds while Reset is low.
- The first push edge after reset release is honoured normally.
- Latency: an entry pushed at edge N appears on Out* with OutValid=1 in the cycle after edge N (1 cycle). No bypass from In* to Out*.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < Count < DEPTH.
- Handshakes complete on the rising edge where valid & ready & ~Flush is high. The producer holds data stable while valid & ~ready. Out* stays stable while OutValid & ~OutReady.
- Flush takes effect at one edge. The cycle after, OutValid=0 and InReady=1.
- Pointer wrap: after DEPTH pushes, WrPtr returns to 0. Order is preserved across the wrap.

## Test plan
- Reset/empty: hold Reset=0 for 2 cycles, then release -> Count=0, OutValid=0, InReady=1, OutInstruction=00000000. With OutReady=1 and no push, Count stays 0.
- Fill to full: push 8C010004, 8C020008, 00221820, AC03000C (PC+4 = 4, 8, C, 10) with OutReady=0 -> Count=4, InReady=0, OutInstruction=8C010004, OutPCPlus4=00000004. A 5th push of 12345678 is ignored.
- Drain in order with wrap: from full, pop 2, push 2 more (08000000, 00000000), then pop all -> outputs in exact order 8C010004, 8C020008, 00221820, AC03000C, 08000000, 00000000, then OutValid=0.
- Simultaneous push/pop at Count=2 -> Count stays 2 and the FIFO order is intact. At Count=4 with OutReady=1 and InValid=1 -> Count becomes 3 and the offered word is not stored.
- Flush with push and pop in the same cycle at Count=3 -> next cycle Count=0, OutValid=0, InReady=1. The next push of 1000FFFF appears at the head one cycle later.
- Async reset mid-operation: assert Reset=0 between clock edges at Count=3 -> Count=0 and OutValid=0 without waiting for Clk. Release -> normal pushes resume.
